ln_norm_sequencer: RTL and testbench

Sequencer for the current/voltage linearize-normalize datapath. Accepts one (I, V) single-precision sample pair per request, issues the datapath clear pulse, starts both conversions, and collects the two fixed-point results. It presents them as one result beat. It sits between the sample acquisition logic and the linearizer/normalizer pair and is the only driver of that datapath's reset and start inputs.

---
 rtl/ln_seq_pkg.sv | 16 +
 rtl/ln_seq_timer.sv | 35 +++
 rtl/ln_norm_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_ln_norm_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ln_seq_pkg.sv
// Shared types and default sizing for the linearize/normalize sequencer.
package ln_seq_pkg;

  localparam int W_DEF              = 32;
  localparam int RST_PULSE_DEF      = 2;
  localparam int TIMEOUT_CYCLES_DEF = 1023;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    START,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/ln_seq_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ln_seq_timer #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] load_val,
  output logic          expired
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ln_norm_sequencer.sv
// Sequencer for the I/V linearize-normalize datapath: clear, start, collect, strobe.
// Optional WAIT watchdog enabled by defining LN_SEQ_TIMEOUT_EN.
module ln_norm_sequencer
  import ln_seq_pkg::*;
#(
  parameter int W              = W_DEF,
  parameter int RST_PULSE      = RST_PULSE_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         SAMPLE_VALID,
  output logic         SAMPLE_READY,
  input  logic [W-1:0] I_IN,
  input  logic [W-1:0] V_IN,
  output logic         RESULT_VALID,
  output logic [W-1:0] RESULT_I_OUT,
  output logic [W-1:0] RESULT_V_OUT,
  output logic         ERR_TIMEOUT,
  output logic         BUSY,
  output logic [W-1:0] I_DP,
  output logic [W-1:0] V_DP,
  output logic         RST_DP,
  output logic         BEGIN_I,
  output logic         BEGIN_V,
  input  logic         ACK_I,
  input  logic         ACK_V,
  input  logic [W-1:0] RESULT_I,
  input  logic [W-1:0] RESULT_V
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(RST_PULSE - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          armed_q, armed_d;
  logic          flag_i_q, flag_i_d, flag_v_q, flag_v_d;
  logic [W-1:0]  cap_i_q, cap_i_d, cap_v_q, cap_v_d;
  logic [W-1:0]  i_dp_q, i_dp_d, v_dp_q, v_dp_d;
  logic [W-1:0]  res_i_q, res_i_d, res_v_q, res_v_d;
  logic          ready_q, ready_d, valid_q, valid_d, busy_q, busy_d;
  logic          rst_dp_q, rst_dp_d, begin_q, begin_d;
  logic          done_i, done_v;
  logic          timer_load;

`ifdef LN_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic err_q, err_d;
  logic tmr_expired;

  ln_seq_timer #(.CW(CW)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (timer_load),
    .en       (state_q == WAIT),
    .load_val (CW'(TIMEOUT_CYCLES - 1)),
    .expired  (tmr_expired)
  );
`endif

  // A live ACK counts as done so completion is seen in the cycle it arrives.
  assign done_i = flag_i_q | ACK_I;
  assign done_v = flag_v_q | ACK_V;

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    armed_d    = armed_q;
    flag_i_d   = flag_i_q;
    flag_v_d   = flag_v_q;
    cap_i_d    = cap_i_q;
    cap_v_d    = cap_v_q;
    i_dp_d     = i_dp_q;
    v_dp_d     = v_dp_q;
    res_i_d    = res_i_q;
    res_v_d    = res_v_q;
    timer_load = 1'b0;
`ifdef LN_SEQ_TIMEOUT_EN
    err_d      = err_q;
`endif
    case (state_q)
      CLR: begin
        if (pcnt_q == PCNT_LAST) begin
          pcnt_d  = '0;
          armed_d = 1'b0;
          state_d = armed_q ? START : IDLE;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (SAMPLE_VALID && ready_q) begin
          i_dp_d  = I_IN;
          v_dp_d  = V_IN;
          armed_d = 1'b1;
          pcnt_d  = '0;
          state_d = CLR;
`ifdef LN_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      START: begin
        flag_i_d   = 1'b0;
        flag_v_d   = 1'b0;
        timer_load = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (ACK_I && !flag_i_q) begin
          flag_i_d = 1'b1;
          cap_i_d  = RESULT_I;
        end
        if (ACK_V && !flag_v_q) begin
          flag_v_d = 1'b1;
          cap_v_d  = RESULT_V;
        end
        if (done_i && done_v) begin
          res_i_d = flag_i_q ? cap_i_q : RESULT_I;
          res_v_d = flag_v_q ? cap_v_q : RESULT_V;
          state_d = DONE;
        end
`ifdef LN_SEQ_TIMEOUT_EN
        else if (tmr_expired) begin
          err_d   = 1'b1;
          armed_d = 1'b0;
          pcnt_d  = '0;
          state_d = CLR;
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CLR;
      end
    endcase

    // Status outputs are registered copies of the decoded next state.
    ready_d  = (state_d == IDLE);
    valid_d  = (state_d == DONE);
    busy_d   = (state_d != IDLE);
    rst_dp_d = (state_d == CLR);
    begin_d  = (state_d == START);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= CLR;
      pcnt_q   <= '0;
      armed_q  <= 1'b0;
      flag_i_q <= 1'b0;
      flag_v_q <= 1'b0;
      cap_i_q  <= '0;
      cap_v_q  <= '0;
      i_dp_q   <= '0;
      v_dp_q   <= '0;
      res_i_q  <= '0;
      res_v_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b1;
      rst_dp_q <= 1'b1;
      begin_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      armed_q  <= armed_d;
      flag_i_q <= flag_i_d;
      flag_v_q <= flag_v_d;
      cap_i_q  <= cap_i_d;
      cap_v_q  <= cap_v_d;
      i_dp_q   <= i_dp_d;
      v_dp_q   <= v_dp_d;
      res_i_q  <= res_i_d;
      res_v_q  <= res_v_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      rst_dp_q <= rst_dp_d;
      begin_q  <= begin_d;
    end
  end

`ifdef LN_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR_TIMEOUT = err_q;
`else
  assign ERR_TIMEOUT = 1'b0;
`endif

  assign SAMPLE_READY = ready_q;
  assign RESULT_VALID = valid_q;
  assign RESULT_I_OUT = res_i_q;
  assign RESULT_V_OUT = res_v_q;
  assign BUSY         = busy_q;
  assign I_DP         = i_dp_q;
  assign V_DP         = v_dp_q;
  assign RST_DP       = rst_dp_q;
  assign BEGIN_I      = begin_q;
  assign BEGIN_V      = begin_q;

endmodule

// File: tb/tb_ln_norm_sequencer.sv
// Directed self-checking bench for ln_norm_sequencer with a cycle-level datapath model.
// The watchdog scenario runs only when LN_SEQ_TIMEOUT_EN is defined.
module tb_ln_norm_sequencer;

  localparam int W  = 32;
  localparam int RP = 2;
  localparam int TO = 16;
  localparam int NEVER = 100000;

  logic         CLK = 1'b0;
  logic         RST;
  logic         SAMPLE_VALID;
  logic         SAMPLE_READY;
  logic [W-1:0] I_IN, V_IN;
  logic         RESULT_VALID;
  logic [W-1:0] RESULT_I_OUT, RESULT_V_OUT;
  logic         ERR_TIMEOUT;
  logic         BUSY;
  logic [W-1:0] I_DP, V_DP;
  logic         RST_DP;
  logic         BEGIN_I, BEGIN_V;
  logic         ACK_I, ACK_V;
  logic [W-1:0] RESULT_I, RESULT_V;

  always #5 CLK = ~CLK;

  ln_norm_sequencer #(.W(W), .RST_PULSE(RP), .TIMEOUT_CYCLES(TO)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_READY (SAMPLE_READY),
    .I_IN         (I_IN),
    .V_IN         (V_IN),
    .RESULT_VALID (RESULT_VALID),
    .RESULT_I_OUT (RESULT_I_OUT),
    .RESULT_V_OUT (RESULT_V_OUT),
    .ERR_TIMEOUT  (ERR_TIMEOUT),
    .BUSY         (BUSY),
    .I_DP         (I_DP),
    .V_DP         (V_DP),
    .RST_DP       (RST_DP),
    .BEGIN_I      (BEGIN_I),
    .BEGIN_V      (BEGIN_V),
    .ACK_I        (ACK_I),
    .ACK_V        (ACK_V),
    .RESULT_I     (RESULT_I),
    .RESULT_V     (RESULT_V)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int           cyc = 0;
  int           begin_cnt, valid_cnt, begin_cyc, valid_cyc, lockstep_bad;
  int           dly_i, dly_v, dp_t;
  bit           dp_run;
  logic [W-1:0] dp_res_i, dp_res_v;

  logic [W-1:0] b2b_i  [3] = '{32'h3F80_0000, 32'h4040_0000, 32'hC0A0_0000};
  logic [W-1:0] b2b_v  [3] = '{32'h4120_0000, 32'h3F00_0000, 32'h4480_0000};
  logic [W-1:0] b2b_ri [3] = '{32'h0001_0000, 32'h0003_0000, 32'hFFFB_0000};
  logic [W-1:0] b2b_rv [3] = '{32'h000A_0000, 32'h0000_8000, 32'h0400_0000};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: outputs sampled 1 time unit after the edge, then the datapath
  // model reacts. Results are perturbed after the first ACK cycle so any
  // recapture in the sequencer would be visible.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (BEGIN_I) begin
      begin_cnt++;
      begin_cyc = cyc;
    end
    if (BEGIN_I !== BEGIN_V) lockstep_bad++;
    if (RESULT_VALID) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (RST_DP) begin
      dp_run   = 1'b0;
      ACK_I    = 1'b0;
      ACK_V    = 1'b0;
      RESULT_I = '0;
      RESULT_V = '0;
    end else begin
      if (BEGIN_I) begin
        dp_run = 1'b1;
        dp_t   = 0;
      end else if (dp_run) begin
        dp_t++;
      end
      if (ACK_I) RESULT_I = ~dp_res_i;
      else if (dp_run && dp_t >= dly_i) begin
        ACK_I    = 1'b1;
        RESULT_I = dp_res_i;
      end
      if (ACK_V) RESULT_V = ~dp_res_v;
      else if (dp_run && dp_t >= dly_v) begin
        ACK_V    = 1'b1;
        RESULT_V = dp_res_v;
      end
    end
  endtask

  task automatic acceptSample(input logic [W-1:0] i, input logic [W-1:0] v, input string tag,
                              output int accept_cyc);
    bit acc;
    int n;
    I_IN = i;
    V_IN = v;
    SAMPLE_VALID = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = SAMPLE_READY;
      tick();
      n++;
    end
    SAMPLE_VALID = 1'b0;
    I_IN = ~i;
    V_IN = ~v;
    accept_cyc = cyc;
    checkOutput({tag, "_accepted"}, 32'(acc), 32'd1);
  endtask

  task automatic applyStimulus(input logic [W-1:0] i, input logic [W-1:0] v,
                               input int di, input int dv,
                               input logic [W-1:0] ri, input logic [W-1:0] rv,
                               input string tag);
    int accept_cyc, n, dp_bad, dmax;
    dly_i = di;
    dly_v = dv;
    dp_res_i = ri;
    dp_res_v = rv;
    dmax = (di > dv) ? di : dv;
    acceptSample(i, v, tag, accept_cyc);
    checkOutput({tag, "_err_clear"}, 32'(ERR_TIMEOUT), 32'd0);
    begin_cnt = 0;
    valid_cnt = 0;
    dp_bad = 0;
    n = 0;
    while (valid_cnt == 0 && n < 200) begin
      tick();
      n++;
      if (I_DP !== i || V_DP !== v) dp_bad++;
    end
    checkOutput({tag, "_strobes"}, 32'(valid_cnt), 32'd1);
    checkOutput({tag, "_begins"}, 32'(begin_cnt), 32'd1);
    checkOutput({tag, "_begin_lat"}, 32'(begin_cyc - accept_cyc), 32'(RP));
    checkOutput({tag, "_result_lat"}, 32'(valid_cyc - begin_cyc), 32'(dmax + 1));
    checkOutput({tag, "_res_i"}, RESULT_I_OUT, ri);
    checkOutput({tag, "_res_v"}, RESULT_V_OUT, rv);
    checkOutput({tag, "_dp_stable"}, 32'(dp_bad), 32'd0);
    tick();
    checkOutput({tag, "_strobe_len"}, 32'(RESULT_VALID), 32'd0);
    checkOutput({tag, "_ready_again"}, 32'(SAMPLE_READY), 32'd1);
    checkOutput({tag, "_res_i_held"}, RESULT_I_OUT, ri);
  endtask

  initial begin
    int  n, acc_cnt, prev_valid, accept_cyc;
    bit  was_ready;

    RST = 1'b1;
    SAMPLE_VALID = 1'b0;
    I_IN = '0;
    V_IN = '0;
    ACK_I = 1'b0;
    ACK_V = 1'b0;
    RESULT_I = '0;
    RESULT_V = '0;
    dly_i = NEVER;
    dly_v = NEVER;
    dp_res_i = '0;
    dp_res_v = '0;
    dp_run = 1'b0;
    dp_t = 0;
    begin_cnt = 0;
    valid_cnt = 0;
    begin_cyc = 0;
    valid_cyc = 0;
    lockstep_bad = 0;

    // Reset values and release timing
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rst_rst_dp", 32'(RST_DP), 32'd1);
    checkOutput("rst_busy", 32'(BUSY), 32'd1);
    checkOutput("rst_ready", 32'(SAMPLE_READY), 32'd0);
    checkOutput("rst_valid", 32'(RESULT_VALID), 32'd0);
    checkOutput("rst_begin", 32'(BEGIN_I | BEGIN_V), 32'd0);
    checkOutput("rst_err", 32'(ERR_TIMEOUT), 32'd0);
    checkOutput("rst_i_dp", I_DP, 32'd0);
    checkOutput("rst_res_i", RESULT_I_OUT, 32'd0);
    RST = 1'b0;
    begin_cnt = 0;
    tick();
    checkOutput("rel1_rst_dp", 32'(RST_DP), 32'd1);
    checkOutput("rel1_ready", 32'(SAMPLE_READY), 32'd0);
    tick();
    checkOutput("rel2_ready", 32'(SAMPLE_READY), 32'd1);
    checkOutput("rel2_rst_dp", 32'(RST_DP), 32'd0);
    checkOutput("rel2_busy", 32'(BUSY), 32'd0);
    checkOutput("rel_no_begin", 32'(begin_cnt), 32'd0);

    // Nominal conversion, ACK_V before ACK_I
    applyStimulus(32'h3F80_0000, 32'h4000_0000, 10, 4, 32'h0001_0000, 32'h0002_0000, "basic");

    // Both ACKs land in the same cycle
    applyStimulus(32'h4080_0000, 32'hBF80_0000, 5, 5, 32'h0004_0000, 32'hFFFF_0000, "same_ack");

    // Three back-to-back samples with SAMPLE_VALID held high
    dly_i = 3;
    dly_v = 2;
    I_IN = b2b_i[0];
    V_IN = b2b_v[0];
    SAMPLE_VALID = 1'b1;
    acc_cnt = 0;
    begin_cnt = 0;
    valid_cnt = 0;
    n = 0;
    while (valid_cnt < 3 && n < 100) begin
      was_ready = SAMPLE_READY;
      prev_valid = valid_cnt;
      tick();
      n++;
      if (was_ready) begin
        acc_cnt++;
        if (acc_cnt <= 3) begin
          dp_res_i = b2b_ri[acc_cnt-1];
          dp_res_v = b2b_rv[acc_cnt-1];
        end
        if (acc_cnt < 3) begin
          I_IN = b2b_i[acc_cnt];
          V_IN = b2b_v[acc_cnt];
        end
      end
      if (valid_cnt > prev_valid && valid_cnt <= 3) begin
        checkOutput("b2b_res_i", RESULT_I_OUT, b2b_ri[valid_cnt-1]);
        checkOutput("b2b_res_v", RESULT_V_OUT, b2b_rv[valid_cnt-1]);
        checkOutput("b2b_i_dp", I_DP, b2b_i[valid_cnt-1]);
      end
    end
    SAMPLE_VALID = 1'b0;
    repeat (4) tick();
    checkOutput("b2b_strobes", 32'(valid_cnt), 32'd3);
    checkOutput("b2b_begins", 32'(begin_cnt), 32'd3);

    // Reset while waiting with only ACK_I seen
    dly_i = 3;
    dly_v = NEVER;
    dp_res_i = 32'h0007_0000;
    dp_res_v = 32'h0008_0000;
    acceptSample(32'h4100_0000, 32'h4110_0000, "midrst", accept_cyc);
    n = 0;
    while (!ACK_I && n < 50) begin
      tick();
      n++;
    end
    checkOutput("midrst_ack_i_seen", 32'(ACK_I), 32'd1);
    tick();
    valid_cnt = 0;
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midrst_rst_dp", 32'(RST_DP), 32'd1);
    checkOutput("midrst_busy", 32'(BUSY), 32'd1);
    checkOutput("midrst_ready", 32'(SAMPLE_READY), 32'd0);
    checkOutput("midrst_i_dp", I_DP, 32'd0);
    checkOutput("midrst_v_dp", V_DP, 32'd0);
    checkOutput("midrst_res_i", RESULT_I_OUT, 32'd0);
    checkOutput("midrst_res_v", RESULT_V_OUT, 32'd0);
    tick();
    tick();
    RST = 1'b0;
    repeat (3) tick();
    checkOutput("midrst_no_strobe", 32'(valid_cnt), 32'd0);
    applyStimulus(32'h4200_0000, 32'h4210_0000, 2, 6, 32'h0009_0000, 32'h000A_0000, "post_rst");

`ifdef LN_SEQ_TIMEOUT_EN
    // Watchdog: ACK_V never arrives
    dly_i = 2;
    dly_v = NEVER;
    dp_res_i = 32'h0011_0000;
    dp_res_v = 32'h0022_0000;
    acceptSample(32'h4300_0000, 32'h4310_0000, "tmo", accept_cyc);
    begin_cnt = 0;
    valid_cnt = 0;
    n = 0;
    while (!ERR_TIMEOUT && n < 100) begin
      tick();
      n++;
    end
    checkOutput("tmo_err_set", 32'(ERR_TIMEOUT), 32'd1);
    checkOutput("tmo_err_lat", 32'(cyc - begin_cyc), 32'(TO + 1));
    checkOutput("tmo_no_strobe", 32'(valid_cnt), 32'd0);
    tick();
    tick();
    checkOutput("tmo_idle", 32'(SAMPLE_READY), 32'd1);
    checkOutput("tmo_err_sticky", 32'(ERR_TIMEOUT), 32'd1);
    applyStimulus(32'h4400_0000, 32'h4410_0000, 2, 2, 32'h0033_0000, 32'h0044_0000, "tmo_next");
`endif

    checkOutput("begin_lockstep", 32'(lockstep_bad), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
